// File: rtl/inst_rom_loader_pkg.sv
// Shared definitions for the instruction-ROM boot loader: FSM encodings,
// header count width and the instruction-ROM address width used across the SOPC.
package inst_rom_loader_pkg;

    localparam int COUNT_W         = 16;
    localparam int INST_ROM_ADDR_W = 10;

    typedef enum logic [2:0] {
        ST_HDR_HI = 3'd0,
        ST_HDR_LO = 3'd1,
        ST_DATA   = 3'd2,
        ST_CKSUM  = 3'd3,
        ST_FLUSH  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } loader_state_t;

endpackage

// File: rtl/rom_word_asm.sv
// Big-endian byte-to-word assembler: collects four bytes and pulses
// word_valid together with the completed 32-bit word on the fourth byte.
module rom_word_asm (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [7:0] lane_reg [3];
    logic [1:0] cnt_reg;

    // Lane 0 holds the oldest (most significant) byte of the word in progress.
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        always_ff @(posedge clk) begin
            if (rst) begin
                lane_reg[gi] <= 8'h00;
            end else if (byte_valid) begin
                lane_reg[gi] <= (gi == 2) ? byte_data : lane_reg[(gi == 2) ? 2 : gi + 1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= 2'd0;
        end else if (byte_valid) begin
            cnt_reg <= cnt_reg + 2'd1;
        end
    end

    assign word_valid = byte_valid && (cnt_reg == 2'd3);
    assign word_data  = {lane_reg[0], lane_reg[1], lane_reg[2], byte_data};

endmodule

// File: rtl/inst_rom_loader.sv
// Boot loader: writes a host byte stream into the instruction ROM and holds the
// CPU in reset until the image is complete. INST_ROM_LOADER_CHECKSUM_EN adds an XOR checksum byte.
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int ADDR_W = INST_ROM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [31:0]       rom_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    localparam int CW1 = COUNT_W + 1;
    localparam logic [CW1-1:0] DEPTH_C = CW1'(1) << ADDR_W;

    loader_state_t      state_reg;
    logic               in_ready_reg;
    logic               rom_we_reg;
    logic [ADDR_W-1:0]  rom_addr_reg;
    logic [31:0]        rom_wdata_reg;
    logic               cpu_rst_reg;
    logic               done_reg;
    logic               err_reg;
    logic [ADDR_W:0]    word_idx_reg;
    logic [COUNT_W-1:0] count_reg;
`ifdef INST_ROM_LOADER_CHECKSUM_EN
    logic [7:0]         cksum_reg;
`endif

    logic               accept;
    logic               asm_byte_valid;
    logic               word_valid;
    logic [31:0]        word_data;
    logic [CW1-1:0]     hdr_count;
    logic               last_word;

    assign accept         = in_valid && in_ready_reg;
    assign asm_byte_valid = accept && (state_reg == ST_DATA);
    assign hdr_count      = {1'b0, count_reg[15:8], in_data};
    assign last_word      = (CW1'(word_idx_reg) + CW1'(1)) == {1'b0, count_reg};

    rom_word_asm u_asm (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (asm_byte_valid),
        .byte_data  (in_data),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_HDR_HI;
            in_ready_reg  <= 1'b0;
            rom_we_reg    <= 1'b0;
            rom_addr_reg  <= '0;
            rom_wdata_reg <= 32'h0;
            cpu_rst_reg   <= 1'b1;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            word_idx_reg  <= '0;
            count_reg     <= '0;
`ifdef INST_ROM_LOADER_CHECKSUM_EN
            cksum_reg     <= 8'h00;
`endif
        end else begin
            rom_we_reg <= 1'b0;
            case (state_reg)
                ST_HDR_HI: begin
                    in_ready_reg <= 1'b1;
                    if (accept) begin
                        count_reg[15:8] <= in_data;
                        state_reg       <= ST_HDR_LO;
                    end
                end
                ST_HDR_LO: begin
                    if (accept) begin
                        count_reg[7:0] <= in_data;
                        if (hdr_count > DEPTH_C) begin
                            state_reg    <= ST_ERR;
                            in_ready_reg <= 1'b0;
                            err_reg      <= 1'b1;
                        end else if (hdr_count == '0) begin
`ifdef INST_ROM_LOADER_CHECKSUM_EN
                            state_reg    <= ST_CKSUM;
`else
                            state_reg    <= ST_FLUSH;
                            in_ready_reg <= 1'b0;
`endif
                        end else begin
                            state_reg <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
`ifdef INST_ROM_LOADER_CHECKSUM_EN
                    if (accept) begin
                        cksum_reg <= cksum_reg ^ in_data;
                    end
`endif
                    if (word_valid) begin
                        rom_we_reg    <= 1'b1;
                        rom_addr_reg  <= word_idx_reg[ADDR_W-1:0];
                        rom_wdata_reg <= word_data;
                        word_idx_reg  <= word_idx_reg + 1'b1;
                        if (last_word) begin
`ifdef INST_ROM_LOADER_CHECKSUM_EN
                            state_reg    <= ST_CKSUM;
`else
                            state_reg    <= ST_FLUSH;
                            in_ready_reg <= 1'b0;
`endif
                        end
                    end
                end
`ifdef INST_ROM_LOADER_CHECKSUM_EN
                ST_CKSUM: begin
                    if (accept) begin
                        in_ready_reg <= 1'b0;
                        if (in_data == cksum_reg) begin
                            state_reg <= ST_FLUSH;
                        end else begin
                            state_reg <= ST_ERR;
                            err_reg   <= 1'b1;
                        end
                    end
                end
`endif
                ST_FLUSH: begin
                    // Gives the final rom_we a cycle to land before the CPU is released.
                    state_reg   <= ST_DONE;
                    done_reg    <= 1'b1;
                    cpu_rst_reg <= 1'b0;
                end
                ST_DONE: begin
                    in_ready_reg <= 1'b0;
                end
                ST_ERR: begin
                    in_ready_reg <= 1'b0;
                end
                default: begin
                    state_reg    <= ST_ERR;
                    in_ready_reg <= 1'b0;
                    err_reg      <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign rom_we    = rom_we_reg;
    assign rom_addr  = rom_addr_reg;
    assign rom_wdata = rom_wdata_reg;
    assign cpu_rst   = cpu_rst_reg;
    assign done      = done_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Scoreboard bench for inst_rom_loader: expected ROM writes are queued by the
// stimulus and consumed by a monitor that watches rom_we.
module tb_inst_rom_loader;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_wdata;
    logic              cpu_rst;
    logic              done;
    logic              err;

    inst_rom_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .rom_we    (rom_we),
        .rom_addr  (rom_addr),
        .rom_wdata (rom_wdata),
        .cpu_rst   (cpu_rst),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t        sb[$];
    int         total = 0;
    int         bad = 0;
    logic       prev_we = 1'b0;
    logic [7:0] stream[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (rom_we) begin
            check("rom_we_single_cycle", {31'b0, prev_we}, 32'd0);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: addr=%0d data=0x%08h, expected none", rom_addr, rom_wdata);
            end else begin
                e = sb.pop_front();
                $display("write addr=%0d data=0x%08h (expected addr=%0d data=0x%08h)",
                         rom_addr, rom_wdata, e.addr, e.data);
                check("rom_addr", 32'(rom_addr), 32'(e.addr));
                check("rom_wdata", rom_wdata, e.data);
            end
        end
        prev_we = rom_we;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte after `gap` idle cycles and hold it until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: byte 0x%02h not accepted, in_ready=%0b expected 1", b, in_ready);
            in_valid = 1'b0;
            return;
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_stream(input int gap_seed);
        for (int i = 0; i < stream.size(); i++) begin
            send_byte(stream[i], (gap_seed == 0) ? 0 : ((i * 7 + gap_seed) % 5));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic build_two_word();
        logic [7:0] x;
        stream = '{8'h00, 8'h02, 8'h34, 8'h01, 8'h11, 8'h00, 8'h34, 8'h21, 8'h01, 8'h01};
`ifdef INST_ROM_LOADER_CHECKSUM_EN
        x = 8'h00;
        for (int i = 2; i < 10; i++) x ^= stream[i];
        stream.push_back(x);
`else
        x = 8'h00;
`endif
    endtask

    task automatic expect_two_word();
        sb.push_back('{addr: 10'd0, data: 32'h34011100});
        sb.push_back('{addr: 10'd1, data: 32'h34210101});
    endtask

    // Called right after the final byte was accepted.
    task automatic check_finish(input string tag);
        check({tag, "_flush_done"}, 32'(done), 32'd0);
        check({tag, "_flush_cpu_rst"}, 32'(cpu_rst), 32'd1);
        check({tag, "_flush_in_ready"}, 32'(in_ready), 32'd0);
        tick();
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        repeat (3) tick();
        check({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_rom_we", 32'(rom_we), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_rom_wdata", rom_wdata, 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        tick();
        check("ready_after_rst", 32'(in_ready), 32'd1);

        // Two-word image, back-to-back bytes.
        build_two_word();
        expect_two_word();
        send_stream(0);
        check_finish("two_word");

        // Empty image.
        do_reset();
        stream = '{8'h00, 8'h00};
`ifdef INST_ROM_LOADER_CHECKSUM_EN
        stream.push_back(8'h00);
`endif
        send_stream(0);
        check_finish("empty");

        // Oversized header.
        do_reset();
        stream = '{8'h04, 8'h01};
        send_stream(0);
        check("oversize_err", 32'(err), 32'd1);
        check("oversize_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) tick();
        in_valid = 1'b0;
        check("oversize_cpu_rst", 32'(cpu_rst), 32'd1);
        check("oversize_done", 32'(done), 32'd0);
        check("oversize_err_sticky", 32'(err), 32'd1);

        // N == DEPTH is a legal count.
        do_reset();
        stream = '{8'(DEPTH >> 8), 8'(DEPTH & 8'hFF)};
        send_stream(0);
        check("depth_err", 32'(err), 32'd0);
        check("depth_in_ready", 32'(in_ready), 32'd1);

        // Same image with idle gaps between bytes.
        do_reset();
        build_two_word();
        expect_two_word();
        send_stream(3);
        check_finish("gapped");

        // Reset arriving with the 4th byte of a word: write suppressed, byte ignored.
        do_reset();
        stream = '{8'h00, 8'h01, 8'h34, 8'h01, 8'h11};
        send_stream(0);
        in_valid = 1'b1;
        in_data  = 8'h00;
        rst = 1'b1;
        tick();
        check("rst_suppress_we", 32'(rom_we), 32'd0);
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Abort after 5 data bytes, then resend the full image.
        stream = '{8'h00, 8'h02, 8'h34, 8'h01, 8'h11, 8'h00, 8'h34};
        sb.push_back('{addr: 10'd0, data: 32'h34011100});
        send_stream(0);
        rst = 1'b1;
        tick();
        check("abort_cpu_rst", 32'(cpu_rst), 32'd1);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        tick();
        check("abort_ready_again", 32'(in_ready), 32'd1);
        build_two_word();
        expect_two_word();
        send_stream(0);
        check_finish("resend");

`ifdef INST_ROM_LOADER_CHECKSUM_EN
        // Wrong checksum byte.
        do_reset();
        build_two_word();
        void'(stream.pop_back());
        stream.push_back(8'hFF);
        expect_two_word();
        send_stream(0);
        repeat (2) tick();
        check("bad_cksum_err", 32'(err), 32'd1);
        check("bad_cksum_done", 32'(done), 32'd0);
        check("bad_cksum_cpu_rst", 32'(cpu_rst), 32'd1);
        check("bad_cksum_sb", 32'(sb.size()), 32'd0);
`endif

        repeat (2) tick();
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
